// File: rtl/seq_multiplier.sv
// Sequential radix-2 shift-add multiplier with trigger/ready/done handshake.
// Define SEQ_MULTIPLIER_SIGNED_EN to build in two's-complement support via signed_cal.
//
// state  | meaning
// IDLE   | ready=1, waiting for trigger
// CALC   | one shift-add iteration per edge, C_WIDTH edges total
// DONE   | done=1 for one cycle, p holds the new product
module seq_multiplier #(
  parameter int C_WIDTH = 32
) (
  input  logic                   ctl_clk,
  input  logic                   reset,
  input  logic [C_WIDTH-1:0]     a,
  input  logic [C_WIDTH-1:0]     b,
  input  logic                   signed_cal,
  input  logic                   trigger,
  output logic [2*C_WIDTH-1:0]   p,
  output logic                   ready,
  output logic                   done
);

  localparam int CNT_W = $clog2(C_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [C_WIDTH-1:0]   mcand;
  logic [C_WIDTH-1:0]   mplr;
  logic [2*C_WIDTH:0]   acc;
  logic [CNT_W-1:0]     cnt;

  logic [C_WIDTH-1:0]   mag_a;
  logic [C_WIDTH-1:0]   mag_b;
  logic [C_WIDTH:0]     add_hi;
  logic [2*C_WIDTH:0]   acc_step;
  logic [2*C_WIDTH-1:0] prod;
  logic [2*C_WIDTH-1:0] result;
  logic                 accept;
  logic                 last_iter;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
  logic neg;
  logic sign_in;

  // The most negative value negates to itself, which read unsigned is exactly 2^(C_WIDTH-1).
  assign mag_a   = (signed_cal && a[C_WIDTH-1]) ? (~a + C_WIDTH'(1)) : a;
  assign mag_b   = (signed_cal && b[C_WIDTH-1]) ? (~b + C_WIDTH'(1)) : b;
  assign sign_in = signed_cal & (a[C_WIDTH-1] ^ b[C_WIDTH-1]);
  assign result  = neg ? (~prod + (2*C_WIDTH)'(1)) : prod;
`else
  logic unused_signed_cal;

  assign unused_signed_cal = signed_cal;
  assign mag_a  = a;
  assign mag_b  = b;
  assign result = prod;
`endif

  // Partial product lives in the upper C_WIDTH+1 bits so the add never loses its carry.
  assign add_hi    = acc[2*C_WIDTH:C_WIDTH] + {1'b0, (mplr[0] ? mcand : {C_WIDTH{1'b0}})};
  assign acc_step  = {add_hi, acc[C_WIDTH-1:0]} >> 1;
  assign prod      = acc_step[2*C_WIDTH-1:0];
  assign accept    = (state == S_IDLE) && trigger;
  assign last_iter = (state == S_CALC) && (cnt == CNT_LAST);

  always_ff @(posedge ctl_clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (trigger) state_nxt = S_CALC;
      end
      S_CALC: begin
        if (cnt == CNT_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ctl_clk or negedge reset) begin
    if (!reset) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
      p     <= '0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
      neg   <= 1'b0;
`endif
    end else if (accept) begin
      mcand <= mag_a;
      mplr  <= mag_b;
      acc   <= '0;
      cnt   <= '0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
      neg   <= sign_in;
`endif
    end else if (state == S_CALC) begin
      acc  <= acc_step;
      mplr <= mplr >> 1;
      cnt  <= cnt + CNT_W'(1);
      if (last_iter) p <= result;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: vector table, random ops against an
// arithmetic reference, and handshake/reset corner sequences.
module tb_seq_multiplier;

  localparam int W = 32;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic          ctl_clk = 1'b0;
  logic          reset;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          signed_cal;
  logic          trigger;
  logic [2*W-1:0] p;
  logic          ready;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;
  int overlap  = 0;

  seq_multiplier #(.C_WIDTH(W)) dut (
    .ctl_clk    (ctl_clk),
    .reset      (reset),
    .a          (a),
    .b          (b),
    .signed_cal (signed_cal),
    .trigger    (trigger),
    .p          (p),
    .ready      (ready),
    .done       (done)
  );

  always #5 ctl_clk = ~ctl_clk;

  always @(negedge ctl_clk) if (reset === 1'b1 && ready === 1'b1 && done === 1'b1) overlap++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string         name;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          s;
    logic [2*W-1:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Reference: widen both operands to 2W bits (sign- or zero-extended) and multiply modulo 2^2W.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [2*W-1:0] ex, ey;
    if (SIGNED_EN && s) begin
      ex = {{W{x[W-1]}}, x};
      ey = {{W{y[W-1]}}, y};
    end else begin
      ex = {{W{1'b0}}, x};
      ey = {{W{1'b0}}, y};
    end
    return ex * ey;
  endfunction

  task automatic wait_ready(input string name);
    int n = 0;
    while (ready !== 1'b1 && n < 3 * W) begin
      @(negedge ctl_clk);
      n++;
    end
    check({name, " ready timeout"}, 64'(ready), 64'(1));
  endtask

  // One operation; glitch_k>0 re-asserts trigger with new operands after edge E<glitch_k>.
  task automatic run_op(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic s, input logic [2*W-1:0] exp, input int glitch_k);
    int done_at;
    int done_cnt;
    logic [2*W-1:0] p_at_done;
    done_at   = -1;
    done_cnt  = 0;
    p_at_done = '0;
    @(negedge ctl_clk);
    check({name, " ready before"}, 64'(ready), 64'(1));
    a = xa; b = xb; signed_cal = s; trigger = 1'b1;
    @(posedge ctl_clk);
    @(negedge ctl_clk);
    trigger = 1'b0;
    a = $urandom; b = $urandom; signed_cal = 1'($urandom);
    check({name, " ready after accept"}, 64'(ready), 64'(0));
    for (int k = 1; k <= W + 4; k++) begin
      @(negedge ctl_clk);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at   = k;
          p_at_done = p;
        end
      end
      if (k == W + 1) check({name, " ready after done"}, 64'(ready), 64'(1));
      if (k == glitch_k) begin
        trigger = 1'b1; a = $urandom; b = $urandom;
      end else begin
        trigger = 1'b0;
      end
    end
    check({name, " done edge"}, 64'(done_at), 64'(W));
    check({name, " done count"}, 64'(done_cnt), 64'(1));
    check({name, " product"}, p_at_done, exp);
    check({name, " product held"}, p, exp);
  endtask

  vec_t vecs[7];

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    int           last, accepts, dones, c;

    vecs[0] = '{"u max*max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
    vecs[1] = '{"s 5*-3", 32'h0000_0005, 32'hFFFF_FFFD, 1'b1,
                SIGNED_EN ? 64'hFFFF_FFFF_FFFF_FFF1 : 64'h0000_0004_FFFF_FFF1};
    vecs[2] = '{"s min*min", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
    vecs[3] = '{"s min*1", 32'h8000_0000, 32'h0000_0001, 1'b1,
                SIGNED_EN ? 64'hFFFF_FFFF_8000_0000 : 64'h0000_0000_8000_0000};
    vecs[4] = '{"u 3*7", 32'd3, 32'd7, 1'b0, 64'd21};
    vecs[5] = '{"u 0*x", 32'd0, 32'hDEAD_BEEF, 1'b0, 64'd0};
    vecs[6] = '{"s -1*-1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
                SIGNED_EN ? 64'd1 : 64'hFFFF_FFFE_0000_0001};

    reset = 1'b0; a = '0; b = '0; signed_cal = 1'b0; trigger = 1'b0;
    #12;
    check("reset p", p, 64'd0);
    check("reset ready", 64'(ready), 64'(1));
    check("reset done", 64'(done), 64'(0));
    @(negedge ctl_clk);
    reset = 1'b1;
    repeat (5) @(negedge ctl_clk);
    check("idle p", p, 64'd0);
    check("idle ready", 64'(ready), 64'(1));
    check("idle done", 64'(done), 64'(0));

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, 0);

    run_op("glitch", 32'h1234_5678, 32'h0000_0ABC, 1'b0, model(32'h1234_5678, 32'h0000_0ABC, 1'b0), 10);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom);
      if (i % 6 == 0) ra = {1'b1, {(W-1){1'b0}}};
      if (i % 8 == 1) rb = '1;
      run_op("random", ra, rb, rs, model(ra, rb, rs), 0);
    end

    // Held trigger: accepts at every ready, spaced W+2 cycles.
    @(negedge ctl_clk);
    ra = 32'h0001_2345; rb = 32'h0000_6789;
    a = ra; b = rb; signed_cal = 1'b0; trigger = 1'b1;
    last = -1; accepts = 0; dones = 0;
    for (c = 0; c < 3 * (W + 2) + 2; c++) begin
      if (ready === 1'b1) begin
        if (last >= 0) check("held spacing", 64'(c - last), 64'(W + 2));
        last = c;
        accepts++;
      end
      if (done === 1'b1) begin
        dones++;
        check("held product", p, model(ra, rb, 1'b0));
      end
      @(negedge ctl_clk);
    end
    trigger = 1'b0;
    check("held accepts", 64'(accepts), 64'(4));
    check("held dones", 64'(dones), 64'(3));
    wait_ready("held drain");

    // Reset during CALC at E16 discards the operation.
    @(negedge ctl_clk);
    a = '1; b = '1; signed_cal = 1'b0; trigger = 1'b1;
    @(posedge ctl_clk);
    @(negedge ctl_clk);
    trigger = 1'b0;
    repeat (16) @(posedge ctl_clk);
    #1 reset = 1'b0;
    #1;
    check("midreset p", p, 64'd0);
    check("midreset ready", 64'(ready), 64'(1));
    check("midreset done", 64'(done), 64'(0));
    @(negedge ctl_clk);
    @(negedge ctl_clk);
    reset = 1'b1;
    dones = 0;
    repeat (W + 4) begin
      @(negedge ctl_clk);
      if (done === 1'b1) dones++;
    end
    check("midreset no done", 64'(dones), 64'(0));
    check("midreset p held", p, 64'd0);
    run_op("after reset 3*7", 32'd3, 32'd7, 1'b0, 64'd21, 0);

    check("ready/done overlap", 64'(overlap), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
